vram_write_sched: RTL and testbench
===================================

Name: vram_write_sched

Overview:
- Sequences all writes into the tile-display memories: board RAM (tile map), sprite RAM (sprite pixels) and colour palette.
- Drives the display compute block's operation/data bus.
- Arbitrates between a CPU command stream and an internal board-fill engine (clear or fill a range of tiles).
- Enforces the two-cycle write protocol the memories require: target bits one cycle, address/data held one more.

Parameters:
- BOARD_DEPTH, 2048, number of board entries; fill addresses wrap modulo this value.
- FILL_CNT_W, 12, width of fill_count.

Ports:
- clock  input  1  system clock
- reset  input  1  synchronous, active-high
- cpu_valid  input  1  CPU write command valid
- cpu_ready  output  1  command accepted when cpu_valid & cpu_ready at a rising edge
- cpu_op  input  32  [17:16] target (01 board, 10 sprites, 11 colours, 00 no-op); [12:0] address
- cpu_data  input  32  write data
- fill_start  input  1  one-cycle request to start a fill
- fill_base  input  11  first board address
- fill_count  input  FILL_CNT_W  number of entries to write
- fill_tile  input  5  tile index written to each entry
- vblank  input  1  vertical blanking from display timing
- fill_busy  output  1  fill engine active
- fill_done  output  1  one-cycle pulse at fill completion
- operation  output  32  to compute block
- data  output  32  to compute block

Behaviour:
- Reset: state IDLE; operation=0, data=0, cpu_ready=0, fill_busy=0, fill_done=0; last_grant=FILL, so the CPU wins the first contention. Reset mid-fill aborts the fill with no fill_done pulse.
- FSM states: IDLE, SET, HOLD.
- Each write occupies SET then HOLD:
  - SET: operation = command with target bits set, data = payload.
  - HOLD: same address and data; operation[17:16] forced to 00.
  - Result: exactly one memory write per command.
- Grant evaluation happens in IDLE and HOLD.
  - Requesters: CPU (cpu_valid, and target eligible) and fill (fill_busy with entries remaining).
  - Both requesting: round-robin opposite to last_grant.
  - One requesting: it wins. last_grant updates on every grant.
  - Grant → SET next cycle. No grant → IDLE next cycle, with operation=0 and data=0.
- Sustained throughput: one write per 2 cycles.
- cpu_ready is combinational. It is high only in IDLE/HOLD when the CPU wins the grant that cycle.
- CPU no-op (target 00): accepted, consumes no SET/HOLD slot, state unchanged.
- Fill engine:
  - fill_start is sampled only when fill_busy=0; ignored otherwise.
  - On acceptance: latch base, count and tile; fill_busy=1 from the next cycle.
  - Each fill write: operation = {14'b0, 2'b01, 5'b0, addr[10:0]}, data = {27'b0, fill_tile}.
  - addr increments by 1 per write; addr = BOARD_DEPTH-1 wraps to 0.
  - fill_busy falls, and fill_done pulses, in the cycle after the HOLD of the last fill write.
  - fill_count=0: no writes, fill_busy stays 0, fill_done pulses the cycle after fill_start.
- fill_start and cpu_valid together in IDLE: the CPU is granted (fill not yet busy); the fill joins arbitration next cycle.
- Commands are never reordered within a source. A CPU command is passed verbatim except for target-bit masking in HOLD.

Optional Feature:
- Macro: PALETTE_VBLANK_EN.
- Defined: CPU commands with target 11 are eligible only while vblank=1.
  - While ineligible, cpu_ready stays 0 and the fill engine may take slots.
  - An already-granted palette write completes SET/HOLD even if vblank falls.
- Undefined: vblank is ignored; palette writes are issued like any other.

Test Plan:
- Reset, then CPU op=0x0001_0005, data=0x0000_0003 → cycle after accept: operation=0x0001_0005, data=3; next cycle operation=0x0000_0005, data=3; then operation=0, data=0.
- Fill base=2046, count=4, tile=7 → board writes at addresses 2046, 2047, 0, 1 (data=7), one every 2 cycles; fill_done pulses once; fill_busy spans the whole fill.
- Fill count=10 active while CPU streams 5 sprite writes → grants alternate CPU/fill; all 5 CPU writes and 10 fill writes issued; no dropped or duplicated SET cycles.
- fill_start while busy with count=3 → ignored; only the original fill's writes occur.
- PALETTE_VBLANK_EN defined, CPU op=0x0003_0010 with vblank=0 for 20 cycles, then 1 → cpu_ready low until vblank=1; write issued afterward. Undefined → write issued immediately.
- Reset asserted during the HOLD of fill write 2 of 8 → next cycle operation=0, fill_busy=0; no fill_done pulse; no further writes.

Source files
------------

// File: rtl/vram_write_sched.sv
// vram_write_sched: write sequencer for the tile-display memories (board RAM,
// sprite RAM, colour palette). Arbitrates between a CPU command stream and a
// board-fill engine and issues every write as a SET cycle (target bits set)
// followed by a HOLD cycle (same address/data, target bits cleared).
//
// Build option: define PALETTE_VBLANK_EN to restrict CPU palette writes
// (target 11) to vertical blanking. Without it vblank is ignored.
module vram_write_sched #(
    parameter int BOARD_DEPTH = 2048,
    parameter int FILL_CNT_W  = 12
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  cpu_valid,
    output logic                  cpu_ready,
    input  logic [31:0]           cpu_op,
    input  logic [31:0]           cpu_data,
    input  logic                  fill_start,
    input  logic [10:0]           fill_base,
    input  logic [FILL_CNT_W-1:0] fill_count,
    input  logic [4:0]            fill_tile,
    input  logic                  vblank,
    output logic                  fill_busy,
    output logic                  fill_done,
    output logic [31:0]           operation,
    output logic [31:0]           data
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SET  = 2'd1,
        HOLD = 2'd2
    } state_t;

    localparam logic        GRANT_CPU  = 1'b0;
    localparam logic        GRANT_FILL = 1'b1;
    localparam logic [10:0] ADDR_LAST  = 11'(BOARD_DEPTH - 1);

    state_t                state_q;
    logic                  last_grant_q;
    logic                  fill_busy_q;
    logic                  fill_done_q;
    logic                  hold_fill_q;
    logic [FILL_CNT_W-1:0] fill_rem_q;
    logic [10:0]           fill_addr_q;
    logic [10:0]           fill_addr_d;
    logic [4:0]            fill_tile_q;
    logic [31:0]           op_q;
    logic [31:0]           data_q;

    logic cpu_elig;
    logic cpu_req;
    logic cpu_noop;
    logic fill_req;
    logic slot_open;
    logic grant_cpu;
    logic grant_fill;
    logic fill_last_hold;

`ifdef PALETTE_VBLANK_EN
    // Palette writes only become requests during vertical blanking.
    always_comb begin
        cpu_elig = (cpu_op[17:16] != 2'b11) || vblank;
    end
`else
    logic unused_vblank;
    assign unused_vblank = vblank;

    // Every CPU command is eligible when palette gating is not built in.
    always_comb begin
        cpu_elig = 1'b1;
    end
`endif

    // Round-robin grant: a new write can only start where the previous one
    // is not in its SET cycle; on contention the source not granted last wins.
    always_comb begin
        cpu_req        = cpu_valid && cpu_elig;
        cpu_noop       = (cpu_op[17:16] == 2'b00);
        fill_req       = fill_busy_q && (fill_rem_q != '0);
        slot_open      = (state_q != SET);
        grant_cpu      = slot_open && cpu_req &&
                         (!fill_req || (last_grant_q == GRANT_FILL));
        grant_fill     = slot_open && fill_req &&
                         (!cpu_req || (last_grant_q == GRANT_CPU));
        fill_last_hold = (state_q == HOLD) && hold_fill_q && (fill_rem_q == '0);
        fill_addr_d    = (fill_addr_q == ADDR_LAST) ? 11'd0 : fill_addr_q + 11'd1;
    end

    // Sequencer FSM, fill engine bookkeeping and registered output bus.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= IDLE;
            last_grant_q <= GRANT_FILL;
            fill_busy_q  <= 1'b0;
            fill_done_q  <= 1'b0;
            hold_fill_q  <= 1'b0;
            fill_rem_q   <= '0;
            op_q         <= '0;
            data_q       <= '0;
        end else begin
            fill_done_q <= 1'b0;

            // A new fill is only taken while the engine is free; a zero-length
            // fill completes immediately without ever going busy.
            if (fill_start && !fill_busy_q) begin
                fill_addr_q <= fill_base;
                fill_rem_q  <= fill_count;
                fill_tile_q <= fill_tile;
                if (fill_count != '0) begin
                    fill_busy_q <= 1'b1;
                end else begin
                    fill_done_q <= 1'b1;
                end
            end

            case (state_q)
                IDLE, HOLD: begin
                    // The HOLD of the last fill write retires the fill.
                    if (fill_last_hold) begin
                        fill_busy_q <= 1'b0;
                        fill_done_q <= 1'b1;
                    end
                    if (grant_cpu && !cpu_noop) begin
                        op_q         <= cpu_op;
                        data_q       <= cpu_data;
                        hold_fill_q  <= 1'b0;
                        last_grant_q <= GRANT_CPU;
                        state_q      <= SET;
                    end else if (grant_fill) begin
                        op_q         <= {14'b0, 2'b01, 5'b0, fill_addr_q};
                        data_q       <= {27'b0, fill_tile_q};
                        fill_addr_q  <= fill_addr_d;
                        fill_rem_q   <= fill_rem_q - FILL_CNT_W'(1);
                        hold_fill_q  <= 1'b1;
                        last_grant_q <= GRANT_FILL;
                        state_q      <= SET;
                    end else begin
                        // No write this slot; a CPU no-op still counts as a grant.
                        if (grant_cpu) begin
                            last_grant_q <= GRANT_CPU;
                        end
                        op_q    <= '0;
                        data_q  <= '0;
                        state_q <= IDLE;
                    end
                end
                SET: begin
                    op_q[17:16] <= 2'b00;
                    state_q     <= HOLD;
                end
                default: begin
                    op_q    <= '0;
                    data_q  <= '0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign cpu_ready = grant_cpu;
    assign fill_busy = fill_busy_q;
    assign fill_done = fill_done_q;
    assign operation = op_q;
    assign data      = data_q;

endmodule

// File: tb/tb_vram_write_sched.sv
// Scoreboard bench for vram_write_sched: drivers push expected writes per
// source, a negedge monitor pops and checks every SET/HOLD/IDLE cycle and
// tracks the expected fill_busy/fill_done waveform.
module tb_vram_write_sched;

    logic        clock = 1'b0;
    logic        reset;
    logic        cpu_valid;
    logic        cpu_ready;
    logic [31:0] cpu_op;
    logic [31:0] cpu_data;
    logic        fill_start;
    logic [10:0] fill_base;
    logic [11:0] fill_count;
    logic [4:0]  fill_tile;
    logic        vblank;
    logic        fill_busy;
    logic        fill_done;
    logic [31:0] operation;
    logic [31:0] data;

    always #5 clock = ~clock;

    vram_write_sched #(.BOARD_DEPTH(2048), .FILL_CNT_W(12)) dut (
        .clock(clock), .reset(reset),
        .cpu_valid(cpu_valid), .cpu_ready(cpu_ready),
        .cpu_op(cpu_op), .cpu_data(cpu_data),
        .fill_start(fill_start), .fill_base(fill_base),
        .fill_count(fill_count), .fill_tile(fill_tile),
        .vblank(vblank), .fill_busy(fill_busy), .fill_done(fill_done),
        .operation(operation), .data(data)
    );

    typedef struct packed {
        logic [31:0] op;
        logic [31:0] dat;
    } wr_t;

    wr_t cpuq[$];
    wr_t fillq[$];
    int  set_cycles[$];
    int  src_log[$];

    int errors = 0;
    int checks = 0;

    bit  mon_en = 0;
    bit  hold_pending = 0;
    bit  hold_fill = 0;
    wr_t hold_wr;
    bit  busy_exp = 0;
    bit  busy_cur = 0;
    bit  done_due = 0;
    bit  rand_vb = 0;
    int  cyc = 0;
    int  done_cnt = 0;
    int  fill_sets = 0;
    logic [31:0] m;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Monitor / scoreboard
    always @(negedge clock) begin
        cyc++;
        if (mon_en) begin
            chk("fill_done", 32'(fill_done), 32'(done_due));
            chk("fill_busy", 32'(fill_busy), 32'(busy_exp));
            busy_cur = busy_exp;
            if (fill_done) done_cnt++;
            done_due = 0;
`ifdef PALETTE_VBLANK_EN
            if (cpu_valid && cpu_op[17:16] == 2'b11 && !vblank)
                chk("palette_gate", 32'(cpu_ready), 32'd0);
`endif
            if (hold_pending) begin
                m = hold_wr.op;
                m[17:16] = 2'b00;
                chk("hold_op", operation, m);
                chk("hold_data", data, hold_wr.dat);
                hold_pending = 0;
                if (hold_fill && fillq.size() == 0 && busy_exp) begin
                    done_due = 1;
                    busy_exp = 0;
                end
            end else if (operation[17:16] != 2'b00) begin
                if (cpu_valid) chk("ready_in_set", 32'(cpu_ready), 32'd0);
                set_cycles.push_back(cyc);
                if (fillq.size() > 0 && operation == fillq[0].op && data == fillq[0].dat) begin
                    hold_wr = fillq.pop_front();
                    hold_fill = 1;
                    fill_sets++;
                    src_log.push_back(1);
                    chk("busy_at_fill", 32'(fill_busy), 32'd1);
                end else if (cpuq.size() > 0) begin
                    hold_wr = cpuq.pop_front();
                    hold_fill = 0;
                    src_log.push_back(0);
                    chk("cpu_op", operation, hold_wr.op);
                    chk("cpu_data", data, hold_wr.dat);
                end else begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_write: got op %h data %h, expected no write", operation, data);
                    hold_wr.op = operation;
                    hold_wr.dat = data;
                    hold_fill = 0;
                end
                hold_pending = 1;
            end else begin
                chk("idle_op", operation, 32'd0);
                chk("idle_data", data, 32'd0);
            end
        end
    end

    // Called aligned at posedge+1; returns aligned at posedge+1 after acceptance.
    task automatic cpu_send(input logic [31:0] op, input logic [31:0] dat, output int waited);
        bit  acc;
        wr_t e;
        waited = 0;
        acc = 0;
        cpu_valid = 1'b1;
        cpu_op = op;
        cpu_data = dat;
        while (!acc && waited < 200) begin
            if (rand_vb) vblank = 1'($urandom_range(0, 1));
            @(negedge clock);
            if (cpu_ready) begin
                acc = 1;
                e.op = op;
                e.dat = dat;
                cpuq.push_back(e);
            end
            @(posedge clock);
            #1;
            if (!acc) waited++;
        end
        if (!acc) begin
            checks++;
            errors++;
            $display("FAIL cpu_accept_timeout: got no cpu_ready in %0d cycles, expected acceptance", waited);
        end
        cpu_valid = 1'b0;
    endtask

    // Called aligned at posedge+1; returns aligned at posedge+1.
    task automatic start_fill(input logic [10:0] b, input logic [11:0] c, input logic [4:0] t);
        bit  acc;
        wr_t e;
        fill_base = b;
        fill_count = c;
        fill_tile = t;
        fill_start = 1'b1;
        @(posedge clock);
        acc = !busy_cur;
        #1;
        fill_start = 1'b0;
        if (acc) begin
            if (c == 12'd0) begin
                done_due = 1;
            end else begin
                busy_exp = 1;
                for (int i = 0; i < int'(c); i++) begin
                    e.op = 32'h0001_0000 | 32'((int'(b) + i) % 2048);
                    e.dat = 32'(t);
                    fillq.push_back(e);
                end
            end
        end
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((busy_exp || done_due || hold_pending || fillq.size() != 0 || cpuq.size() != 0) && n < 500) begin
            @(posedge clock);
            #1;
            n++;
        end
        if (n >= 500) begin
            checks++;
            errors++;
            $display("FAIL idle_timeout: got pending fill=%0d cpu=%0d after %0d cycles, expected drained", fillq.size(), cpuq.size(), n);
        end
        repeat (3) begin
            @(posedge clock);
            #1;
        end
    endtask

    function automatic logic [31:0] rand_cpu_op(input logic [1:0] tgt);
        logic [31:0] o;
        o = $urandom;
        o[31] = 1'b1;
        o[17:16] = tgt;
        return o;
    endfunction

    initial begin
        #500000;
        $display("FAIL watchdog: got no finish, expected bench to end");
        $fatal(1, "watchdog");
    end

    initial begin
        int w, d0, f0, n;
        reset = 1'b1;
        cpu_valid = 1'b0;
        cpu_op = '0;
        cpu_data = '0;
        fill_start = 1'b0;
        fill_base = '0;
        fill_count = '0;
        fill_tile = '0;
        vblank = 1'b1;

        // Reset state
        @(posedge clock);
        @(negedge clock);
        chk("rst_op", operation, 32'd0);
        chk("rst_data", data, 32'd0);
        chk("rst_ready", 32'(cpu_ready), 32'd0);
        chk("rst_busy", 32'(fill_busy), 32'd0);
        chk("rst_done", 32'(fill_done), 32'd0);
        @(posedge clock);
        #1;
        reset = 1'b0;
        mon_en = 1;

        // Single CPU board write: SET, HOLD, then idle bus
        cpu_send(32'h0001_0005, 32'h0000_0003, w);
        chk("t1_latency", 32'(w), 32'd0);
        @(negedge clock);
        chk("t1_set_op", operation, 32'h0001_0005);
        chk("t1_set_data", data, 32'd3);
        @(negedge clock);
        chk("t1_hold_op", operation, 32'h0000_0005);
        chk("t1_hold_data", data, 32'd3);
        @(negedge clock);
        chk("t1_idle_op", operation, 32'd0);
        @(posedge clock);
        #1;
        wait_idle();

        // Wrapping fill, one write every two cycles
        set_cycles.delete();
        d0 = done_cnt;
        start_fill(11'd2046, 12'd4, 5'd7);
        wait_idle();
        chk("t2_writes", 32'(set_cycles.size()), 32'd4);
        for (int i = 1; i < set_cycles.size(); i++)
            chk("t2_spacing", 32'(set_cycles[i] - set_cycles[i-1]), 32'd2);
        chk("t2_done_pulses", 32'(done_cnt - d0), 32'd1);

        // CPU sprite stream contending with a 10-entry fill
        src_log.delete();
        fork
            begin
                int wl;
                for (int i = 0; i < 5; i++) cpu_send(rand_cpu_op(2'b10), $urandom, wl);
            end
            start_fill(11'd300, 12'd10, 5'd9);
        join
        wait_idle();
        chk("t3_writes", 32'(src_log.size()), 32'd15);
        for (int i = 0; i < src_log.size() && i < 15; i++)
            chk("t3_source", 32'(src_log[i]), (i < 10) ? 32'(i % 2) : 32'd1);

        // fill_start while busy is ignored
        d0 = done_cnt;
        start_fill(11'd100, 12'd6, 5'd3);
        repeat (4) begin
            @(posedge clock);
            #1;
        end
        start_fill(11'd500, 12'd3, 5'd1);
        wait_idle();
        chk("t4_done_pulses", 32'(done_cnt - d0), 32'd1);

        // Zero-length fill
        d0 = done_cnt;
        start_fill(11'd42, 12'd0, 5'd4);
        wait_idle();
        chk("t4z_done_pulses", 32'(done_cnt - d0), 32'd1);

        // Palette write held off by vblank (only when gating is built in)
        vblank = 1'b0;
        fork
            cpu_send(32'h0003_0010, 32'h0000_0055, w);
            begin
                repeat (20) @(posedge clock);
                #1;
                vblank = 1'b1;
            end
        join
`ifdef PALETTE_VBLANK_EN
        chk("t5_palette_wait", 32'(w), 32'd20);
`else
        chk("t5_palette_wait", 32'(w), 32'd0);
`endif
        vblank = 1'b1;
        wait_idle();

        // Reset during the HOLD of fill write 2 of 8
        d0 = done_cnt;
        f0 = fill_sets;
        start_fill(11'd700, 12'd8, 5'd12);
        n = 0;
        while (fill_sets < f0 + 2 && n < 100) begin
            @(negedge clock);
            #1;
            n++;
        end
        if (n >= 100) begin
            checks++;
            errors++;
            $display("FAIL t6_wait: got %0d fill writes, expected 2", fill_sets - f0);
        end
        @(posedge clock);
        #1;
        reset = 1'b1;
        @(negedge clock);
        #1;
        mon_en = 0;
        @(posedge clock);
        #1;
        reset = 1'b0;
        @(negedge clock);
        chk("t6_op", operation, 32'd0);
        chk("t6_data", data, 32'd0);
        chk("t6_busy", 32'(fill_busy), 32'd0);
        chk("t6_done", 32'(fill_done), 32'd0);
        fillq.delete();
        cpuq.delete();
        hold_pending = 0;
        busy_exp = 0;
        busy_cur = 0;
        done_due = 0;
        @(posedge clock);
        #1;
        mon_en = 1;
        repeat (30) begin
            @(posedge clock);
            #1;
        end
        chk("t6_no_done", 32'(done_cnt - d0), 32'd0);

        // Randomized mixed traffic
        for (int it = 0; it < 6; it++) begin
            rand_vb = 1;
            fork
                begin
                    int wl;
                    int cnt;
                    cnt = $urandom_range(3, 8);
                    for (int i = 0; i < cnt; i++) begin
                        repeat ($urandom_range(0, 2)) begin
                            @(posedge clock);
                            #1;
                        end
                        cpu_send(rand_cpu_op(2'($urandom_range(1, 3))), $urandom, wl);
                    end
                end
                begin
                    repeat ($urandom_range(0, 4)) begin
                        @(posedge clock);
                        #1;
                    end
                    start_fill(11'($urandom), 12'($urandom_range(0, 12)), 5'($urandom));
                end
            join
            rand_vb = 0;
            vblank = 1'b1;
            wait_idle();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
